// File: rtl/ci_pkg.sv
// Shared widths, FSM state encoding and request record for the CI bus initiator.
package ci_pkg;
  localparam int CI_ID_WIDTH   = 8;
  localparam int CI_DATA_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} ci_init_state_t;

  typedef struct packed {
    logic [CI_ID_WIDTH-1:0]   ciN;
    logic [CI_DATA_WIDTH-1:0] valueA;
    logic [CI_DATA_WIDTH-1:0] valueB;
  } ci_req_t;
endpackage

// File: rtl/ci_initiator_if.sv
// Pipeline request/response plus CI responder bus; master is the initiator side.
interface ci_initiator_if;
  import ci_pkg::*;

  logic                     req_valid;
  logic                     req_ready;
  logic [CI_ID_WIDTH-1:0]   req_ciN;
  logic [CI_DATA_WIDTH-1:0] req_valueA;
  logic [CI_DATA_WIDTH-1:0] req_valueB;
  logic                     cpu_stall;
  logic                     rsp_valid;
  logic [CI_DATA_WIDTH-1:0] rsp_result;
  logic                     rsp_error;
  logic                     ci_start;
  logic [CI_ID_WIDTH-1:0]   ci_ciN;
  logic [CI_DATA_WIDTH-1:0] ci_valueA;
  logic [CI_DATA_WIDTH-1:0] ci_valueB;
  logic                     ci_done;
  logic [CI_DATA_WIDTH-1:0] ci_result;

  modport master (
    input  req_valid, req_ciN, req_valueA, req_valueB, ci_done, ci_result,
    output req_ready, cpu_stall, rsp_valid, rsp_result, rsp_error,
           ci_start, ci_ciN, ci_valueA, ci_valueB
  );

  modport slave (
    output req_valid, req_ciN, req_valueA, req_valueB, ci_done, ci_result,
    input  req_ready, cpu_stall, rsp_valid, rsp_result, rsp_error,
           ci_start, ci_ciN, ci_valueA, ci_valueB
  );
endinterface

// File: rtl/ci_watchdog.sv
// Cycle counter that flags a hung custom instruction (used only with CI_WATCHDOG_EN).
module ci_watchdog #(
  parameter int CI_TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(CI_TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clr) count <= '0;
    else if (en)      count <= count + 1'b1;
  end

  assign expired = (count == CW'(CI_TIMEOUT));
endmodule

// File: rtl/ci_initiator.sv
// CPU-side CI bus initiator: one request -> start pulse -> wait done -> response strobe.
// Define CI_WATCHDOG_EN to abort instructions that never signal done.
module ci_initiator
  import ci_pkg::*;
#(
  parameter int                       CI_TIMEOUT        = 255,
  parameter logic [CI_DATA_WIDTH-1:0] RESULT_ON_TIMEOUT = 32'h0
) (
  input logic            clock,
  input logic            reset,
  ci_initiator_if.master bus
);
  ci_init_state_t           state;
  ci_req_t                  ci_q;
  logic                     req_ready_q;
  logic                     ci_start_q;
  logic                     rsp_valid_q;
  logic [CI_DATA_WIDTH-1:0] rsp_result_q;
  logic                     rsp_error_q;
  logic                     accept;
  logic                     busy;
  logic                     expired;

  assign accept = (state == IDLE) && bus.req_valid;
  assign busy   = (state == START) || (state == WAIT);

`ifdef CI_WATCHDOG_EN
  ci_watchdog #(.CI_TIMEOUT(CI_TIMEOUT)) u_wd (
    .clock   (clock),
    .reset   (reset),
    .clr     (accept),
    .en      (busy),
    .expired (expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^CI_TIMEOUT;
  assign expired    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      ci_q         <= '0;
      req_ready_q  <= 1'b1;
      ci_start_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          state       <= START;
          req_ready_q <= 1'b0;
          ci_start_q  <= 1'b1;
          ci_q        <= '{ciN: bus.req_ciN, valueA: bus.req_valueA, valueB: bus.req_valueB};
        end
        START, WAIT: begin
          ci_start_q <= 1'b0;
          // done beats a simultaneous watchdog expiry
          if (bus.ci_done || expired) begin
            state        <= RESP;
            ci_q         <= '0;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= bus.ci_done ? bus.ci_result : RESULT_ON_TIMEOUT;
            rsp_error_q  <= expired & ~bus.ci_done;
          end else begin
            state <= WAIT;
          end
        end
        RESP: begin
          state        <= IDLE;
          req_ready_q  <= 1'b1;
          rsp_valid_q  <= 1'b0;
          rsp_result_q <= '0;
          rsp_error_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.cpu_stall  = accept || busy;
  assign bus.ci_start   = ci_start_q;
  assign bus.ci_ciN     = ci_q.ciN;
  assign bus.ci_valueA  = ci_q.valueA;
  assign bus.ci_valueB  = ci_q.valueB;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_error  = rsp_error_q;
endmodule

// File: tb/tb_ci_initiator.sv
// Scoreboarded bench for ci_initiator with a behavioural CI responder on the bus.
module tb_ci_initiator;
  import ci_pkg::*;

  localparam int TO = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ci_initiator_if bus();

  ci_initiator #(.CI_TIMEOUT(TO), .RESULT_ON_TIMEOUT(32'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  // responder and stray-done sources are OR-ed like the real bus
  logic        resp_done = 1'b0, spur_done = 1'b0;
  logic [31:0] resp_res = '0, spur_res = '0, resp_tmp;
  assign bus.ci_done   = resp_done | spur_done;
  assign bus.ci_result = resp_res | spur_res;

  int rsp_delay = 0;
  bit rsp_en    = 1'b1;
  int n_assert  = 0;
  int n_fail    = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  logic [31:0] prof_cnt [4] = '{32'd11, 32'd22, 32'd3300, 32'd44};

  function automatic logic [31:0] model(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b);
    if (id == 8'h00) return prof_cnt[a[1:0]];
    if (id == 8'h05) return 32'hDEADBEEF;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  always begin
    @(posedge clock); #1;
    if (bus.ci_start && rsp_en) begin
      resp_tmp = model(bus.ci_ciN, bus.ci_valueA, bus.ci_valueB);
      repeat (rsp_delay) @(posedge clock);
      if (rsp_delay > 0) #1;
      resp_done = 1'b1;
      resp_res  = resp_tmp;
      @(posedge clock); #1;
      resp_done = 1'b0;
      resp_res  = '0;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      n_assert++;
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: rsp_valid=1 result=%h, no request outstanding", bus.rsp_result);
        end else begin
          e = sb.pop_front();
          if (bus.rsp_result !== e.res || bus.rsp_error !== e.err) begin
            n_fail++;
            $display("FAIL rsp_data: result=%h error=%b, expected result=%h error=%b",
                     bus.rsp_result, bus.rsp_error, e.res, e.err);
          end
        end
      end else if (bus.rsp_result !== 32'h0) begin
        n_fail++;
        $display("FAIL rsp_result_idle: result=%h while rsp_valid=0, expected 0", bus.rsp_result);
      end
    end
  end

  task automatic chk(input bit ok, input string name, input logic [95:0] act, input logic [95:0] exp);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    n_assert++;
    if ({bus.ci_start, bus.ci_ciN, bus.ci_valueA, bus.ci_valueB} !== 73'h0) begin
      n_fail++;
      $display("FAIL %s_ci_bus: start=%b id=%h a=%h b=%h, expected all 0",
               tag, bus.ci_start, bus.ci_ciN, bus.ci_valueA, bus.ci_valueB);
    end
  endtask

  task automatic run_req(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] exp_res, input logic exp_err,
                         input string tag);
    int lat;
    n_assert++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: req_ready=%b, expected 1", tag, bus.req_ready); end
    bus.req_valid = 1'b1; bus.req_ciN = id; bus.req_valueA = a; bus.req_valueB = b;
    #1;
    n_assert++;
    if (bus.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL %s_stall_idle: cpu_stall=%b, expected 1", tag, bus.cpu_stall); end
    sb.push_back('{res: exp_res, err: exp_err});
    @(posedge clock); #1;
    bus.req_valid = 1'b0; bus.req_ciN = '0; bus.req_valueA = '0; bus.req_valueB = '0;
    lat = 1;
    n_assert++;
    if (bus.ci_start !== 1'b1 || {bus.ci_ciN, bus.ci_valueA, bus.ci_valueB} !== {id, a, b} || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_start: start=%b id=%h a=%h b=%h ready=%b, expected 1 %h %h %h 0",
               tag, bus.ci_start, bus.ci_ciN, bus.ci_valueA, bus.ci_valueB, bus.req_ready, id, a, b);
    end
    while (!bus.rsp_valid && lat < 60) begin
      @(posedge clock); #1;
      lat++;
      if (!bus.rsp_valid) begin
        n_assert++;
        if (bus.ci_start !== 1'b0 || {bus.ci_ciN, bus.ci_valueA, bus.ci_valueB} !== {id, a, b} || bus.cpu_stall !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_wait: cycle %0d start=%b id=%h a=%h b=%h stall=%b, expected 0 %h %h %h 1",
                   tag, lat, bus.ci_start, bus.ci_ciN, bus.ci_valueA, bus.ci_valueB, bus.cpu_stall, id, a, b);
        end
      end
    end
    n_assert++;
    if (lat != exp_lat) begin n_fail++; $display("FAIL %s_latency: rsp_valid at accept+%0d, expected accept+%0d", tag, lat, exp_lat); end
    n_assert++;
    if (bus.cpu_stall !== 1'b0 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_resp_ctl: stall=%b ready=%b, expected 0 0", tag, bus.cpu_stall, bus.req_ready);
    end
    check_quiet({tag, "_resp"});
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_ciN = '0; bus.req_valueA = '0; bus.req_valueB = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_assert++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_result !== 32'h0 ||
        bus.rsp_error !== 1'b0 || bus.cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b valid=%b result=%h error=%b stall=%b, expected 1 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.cpu_stall);
    end
    check_quiet("reset");
    bus.req_valid = 1'b1;
    #1;
    n_assert++;
    if (bus.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_valid: cpu_stall=%b, expected 1", bus.cpu_stall); end
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_same_cycle();
    rsp_en = 1'b1; rsp_delay = 0;
    run_req(8'h00, 32'd2, 32'd0, 2, prof_cnt[2], 1'b0, "same_cycle");
    run_req(8'h00, 32'd1, 32'd0, 2, prof_cnt[1], 1'b0, "same_cycle2");
  endtask

  task automatic test_multi_cycle();
    rsp_en = 1'b1;
    rsp_delay = 5;
`ifdef CI_WATCHDOG_EN
    run_req(8'h05, 32'h1111, 32'h2222, TO + 2, 32'h0, 1'b1, "multi5_wd");
`else
    run_req(8'h05, 32'h1111, 32'h2222, 7, 32'hDEADBEEF, 1'b0, "multi5");
`endif
    rsp_delay = 1;
    run_req(8'h21, 32'h0F0F_1234, 32'hABCD_0001, 3, model(8'h21, 32'h0F0F_1234, 32'hABCD_0001), 1'b0, "multi1");
    rsp_delay = 0;
  endtask

`ifdef CI_WATCHDOG_EN
  task automatic test_watchdog();
    rsp_en = 1'b0;
    run_req(8'h7F, 32'd1, 32'd2, TO + 2, 32'h0, 1'b1, "wd_expire");
    rsp_en = 1'b1; rsp_delay = TO;
    run_req(8'h10, 32'hA5A5_0000, 32'h0000_1234, TO + 2, model(8'h10, 32'hA5A5_0000, 32'h0000_1234), 1'b0, "wd_done_wins");
    rsp_delay = 0;
  endtask
`endif

  task automatic test_back_to_back();
    int starts[$];
    int rsps[$];
    rsp_en = 1'b1; rsp_delay = 0;
    bus.req_valid = 1'b1; bus.req_ciN = 8'h00; bus.req_valueA = 32'd3; bus.req_valueB = 32'd0;
    sb.push_back('{res: prof_cnt[3], err: 1'b0});
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
      if (c == 1) begin
        bus.req_ciN = 8'h22; bus.req_valueA = 32'h0000_00FF; bus.req_valueB = 32'h1234_5678;
        sb.push_back('{res: model(8'h22, 32'h0000_00FF, 32'h1234_5678), err: 1'b0});
      end
      if (bus.ci_start) starts.push_back(c);
      if (bus.rsp_valid) rsps.push_back(c);
      if (c == 2) chk(bus.req_ready === 1'b0, "b2b_ready_resp", 96'(bus.req_ready), 96'd0);
      if (c == 3) chk(bus.req_ready === 1'b1 && bus.cpu_stall === 1'b1, "b2b_turnaround",
                      96'({bus.req_ready, bus.cpu_stall}), 96'b11);
      if (c == 4) begin
        chk({bus.ci_ciN, bus.ci_valueA} === {8'h22, 32'h0000_00FF}, "b2b_second_ops",
            96'({bus.ci_ciN, bus.ci_valueA}), 96'({8'h22, 32'h0000_00FF}));
        bus.req_valid = 1'b0;
      end
    end
    chk(starts.size() == 2 && starts[0] == 1 && starts[1] == 4, "b2b_starts",
        96'(starts.size() == 2 ? starts[1] : 99), 96'd4);
    chk(rsps.size() == 2 && rsps[0] == 2 && rsps[1] == 5, "b2b_rsps",
        96'(rsps.size() == 2 ? rsps[1] : 99), 96'd5);
  endtask

  task automatic test_reset_mid_wait();
    rsp_en = 1'b0;
    bus.req_valid = 1'b1; bus.req_ciN = 8'h33; bus.req_valueA = 32'hCAFE; bus.req_valueB = 32'hF00D;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    chk(bus.ci_start === 1'b1, "rst_wait_start", 96'(bus.ci_start), 96'd1);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk(dut.state === IDLE, "rst_wait_state", 96'(dut.state), 96'(IDLE));
    chk({bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.cpu_stall, bus.rsp_result} === {4'b1000, 32'h0},
        "rst_wait_outputs", 96'({bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.cpu_stall, bus.rsp_result}),
        96'({4'b1000, 32'h0}));
    check_quiet("rst_wait");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk(bus.rsp_valid === 1'b0, "rst_wait_no_rsp", 96'(bus.rsp_valid), 96'd0);
    end
    rsp_en = 1'b1;
  endtask

  task automatic test_spurious_done();
    spur_done = 1'b1; spur_res = 32'h0000_5A5A;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk(bus.rsp_valid === 1'b0 && bus.req_ready === 1'b1 && dut.state === IDLE && bus.cpu_stall === 1'b0,
          "spurious_idle", 96'({bus.rsp_valid, bus.req_ready, bus.cpu_stall}), 96'b010);
      check_quiet("spurious");
    end
    spur_done = 1'b0; spur_res = '0;
    rsp_delay = 0;
    run_req(8'h00, 32'd0, 32'd0, 2, prof_cnt[0], 1'b0, "after_spurious");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_same_cycle();
    test_multi_cycle();
`ifdef CI_WATCHDOG_EN
    test_watchdog();
`endif
    test_back_to_back();
    test_reset_mid_wait();
    test_spurious_done();
    repeat (3) @(posedge clock);
    #1;
    chk(sb.size() == 0, "sb_drained", 96'(sb.size()), 96'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
